// File: rtl/ls_pkg.sv
// Shared opcodes, FSM states and width defaults for the load/store memory stage.
package ls_pkg;

    localparam int LS_DATA_WIDTH = 32;
    localparam int LS_TAG_WIDTH  = 6;

    // Bit 0 of the opcode is the write flag; bit 1 selects byte-sized access.
    typedef enum logic [1:0] {
        LS_LW  = 2'b00,
        LS_SW  = 2'b01,
        LS_LBU = 2'b10,
        LS_SB  = 2'b11
    } ls_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        CDB  = 2'd2
    } ls_state_e;

    function automatic logic ls_is_store(input ls_op_e op);
        return op[0];
    endfunction

endpackage

// File: rtl/ls_data_align.sv
// Byte-lane steering: byte enables, store-lane replication and load byte
// extraction with zero extension, all keyed by opcode and address low bits.
module ls_data_align
    import ls_pkg::*;
#(
    parameter int DATA_WIDTH = LS_DATA_WIDTH
)(
    input  ls_op_e                i_opcode,
    input  logic [1:0]            i_byte_sel,
    input  logic [DATA_WIDTH-1:0] i_store_data,
    input  logic [DATA_WIDTH-1:0] i_load_word,
    output logic [3:0]            o_be,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic [DATA_WIDTH-1:0] o_load_result
);

    logic [7:0] w_load_byte;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_load_byte = 8'h00;
        case (i_byte_sel)
            2'd0:    w_load_byte = i_load_word[7:0];
            2'd1:    w_load_byte = i_load_word[15:8];
            2'd2:    w_load_byte = i_load_word[23:16];
            default: w_load_byte = i_load_word[31:24];
        endcase
    end

    always_comb begin
        o_be          = 4'b1111;
        o_wdata       = i_store_data;
        o_load_result = i_load_word;
        case (i_opcode)
            LS_SB: begin
                o_be    = 4'b0001 << i_byte_sel;
                o_wdata = {(DATA_WIDTH/8){i_store_data[7:0]}};
            end
            LS_LBU: begin
                o_be          = 4'b0001 << i_byte_sel;
                o_load_result = {{(DATA_WIDTH-8){1'b0}}, w_load_byte};
            end
            default: begin
                o_be = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/load_store_mem_unit.sv
// Memory execution stage: pops one issue-queue entry, performs the data-memory
// access, and broadcasts load results on the CDB.
module load_store_mem_unit
    import ls_pkg::*;
#(
    parameter int DATA_WIDTH = LS_DATA_WIDTH,
    parameter int TAG_WIDTH  = LS_TAG_WIDTH
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issueque_ready,
    input  logic [DATA_WIDTH-1:0] issueque_address,
    input  logic [DATA_WIDTH-1:0] issueque_rs2_data,
    input  logic [TAG_WIDTH-1:0]  issueque_rd_tag,
    input  logic [1:0]            issueque_opcode,
    output logic                  issueblk_done,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  cdb_req,
    input  logic                  cdb_grant,
    output logic [TAG_WIDTH-1:0]  cdb_out_tag,
    output logic [DATA_WIDTH-1:0] cdb_out_data,
    output logic                  busy
);

    ls_state_e             r_state;
    ls_state_e             w_next_state;
    ls_op_e                r_opcode;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_rs2_data;
    logic [DATA_WIDTH-1:0] r_result;
    logic [TAG_WIDTH-1:0]  r_rd_tag;

    logic                  w_accept;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_load_result;

    // Acceptance and queue pop are the same strobe, so it must be gated by reset too.
    assign w_accept = (r_state == IDLE) && issueque_ready && !reset;

    ls_data_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .i_opcode      (r_opcode),
        .i_byte_sel    (r_addr[1:0]),
        .i_store_data  (r_rs2_data),
        .i_load_word   (mem_rdata),
        .o_be          (w_be),
        .o_wdata       (w_wdata),
        .o_load_result (w_load_result)
    );

    // NOTE: state and every latched field use non-blocking assignments and are
    // cleared by reset, so an aborted access leaves nothing behind.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_opcode   <= LS_LW;
            r_addr     <= '0;
            r_rs2_data <= '0;
            r_rd_tag   <= '0;
            r_result   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_opcode   <= ls_op_e'(issueque_opcode);
                r_addr     <= issueque_address;
                r_rs2_data <= issueque_rs2_data;
                r_rd_tag   <= issueque_rd_tag;
            end
            if ((r_state == MEM) && mem_ack && !ls_is_store(r_opcode)) begin
                r_result <= w_load_result;
            end
        end
    end

    // Outputs are forced to zero while reset is high, whatever state is registered.
    always_comb begin
        w_next_state  = r_state;
        issueblk_done = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_be        = 4'b0000;
        cdb_req       = 1'b0;
        cdb_out_tag   = '0;
        cdb_out_data  = '0;
        busy          = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = MEM;
                end
            end
            MEM: begin
                if (mem_ack) begin
                    w_next_state = ls_is_store(r_opcode) ? IDLE : CDB;
                end
            end
            CDB: begin
                if (cdb_grant) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        if (!reset) begin
            issueblk_done = w_accept;
            busy          = (r_state != IDLE);
            if (r_state == MEM) begin
                mem_req   = 1'b1;
                mem_we    = ls_is_store(r_opcode);
                mem_addr  = {r_addr[DATA_WIDTH-1:2], 2'b00};
                mem_wdata = w_wdata;
                mem_be    = w_be;
            end
            if (r_state == CDB) begin
                cdb_req      = 1'b1;
                cdb_out_tag  = r_rd_tag;
                cdb_out_data = r_result;
            end
        end
    end

endmodule

// File: tb/tb_load_store_mem_unit.sv
// Directed bench for load_store_mem_unit: single accesses, stalls, reset abort
// and a back-to-back queue drain with hand-computed expectations.
module tb_load_store_mem_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        issueque_ready;
    logic [31:0] issueque_address;
    logic [31:0] issueque_rs2_data;
    logic [5:0]  issueque_rd_tag;
    logic [1:0]  issueque_opcode;
    logic        issueblk_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        cdb_req;
    logic        cdb_grant;
    logic [5:0]  cdb_out_tag;
    logic [31:0] cdb_out_data;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    load_store_mem_unit #(
        .DATA_WIDTH (32),
        .TAG_WIDTH  (6)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .issueque_ready    (issueque_ready),
        .issueque_address  (issueque_address),
        .issueque_rs2_data (issueque_rs2_data),
        .issueque_rd_tag   (issueque_rd_tag),
        .issueque_opcode   (issueque_opcode),
        .issueblk_done     (issueblk_done),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_be            (mem_be),
        .mem_ack           (mem_ack),
        .mem_rdata         (mem_rdata),
        .cdb_req           (cdb_req),
        .cdb_grant         (cdb_grant),
        .cdb_out_tag       (cdb_out_tag),
        .cdb_out_data      (cdb_out_data),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_entry(input logic rdy, input logic [1:0] op, input logic [31:0] addr,
                             input logic [31:0] rs2, input logic [5:0] tag);
        issueque_ready    = rdy;
        issueque_opcode   = op;
        issueque_address  = addr;
        issueque_rs2_data = rs2;
        issueque_rd_tag   = tag;
    endtask

    function automatic logic any_output();
        return |{issueblk_done, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
                 cdb_req, cdb_out_tag, cdb_out_data, busy};
    endfunction

    // A pop must never coincide with an access already in flight.
    always @(negedge clk) begin
        if (issueblk_done) check("done_while_busy", {63'd0, busy}, 64'd0);
    end

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [5:0]  tag;
    } entry_t;

    entry_t      q [4];
    logic [1:0]  done_op [4];
    int          done_cyc [4];
    logic [5:0]  bc_tag [2];
    logic [31:0] bc_data [2];
    int          idx;
    int          n_done;
    int          n_bcast;

    initial begin
        reset     = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        cdb_grant = 1'b0;
        set_entry(1'b1, 2'b00, 32'h104, 32'h0, 6'h1A);

        // Reset with a ready queue head: nothing may be popped.
        cyc();
        check("rst_done", {63'd0, issueblk_done}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        cyc();
        check("rst_outs", {63'd0, any_output()}, 64'd0);

        // LW 0x104, zero-wait memory and immediate grant.
        cyc();
        reset = 1'b0;
        set_entry(1'b1, 2'b00, 32'h104, 32'h0, 6'h1A);
        #1;
        check("lw_done_n", {63'd0, issueblk_done}, 64'd1);
        check("lw_req_n", {63'd0, mem_req}, 64'd0);
        cyc();
        issueque_ready = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        #1;
        check("lw_req", {63'd0, mem_req}, 64'd1);
        check("lw_addr", {32'd0, mem_addr}, 64'h104);
        check("lw_be", {60'd0, mem_be}, 64'hF);
        check("lw_we", {63'd0, mem_we}, 64'd0);
        check("lw_done_n1", {63'd0, issueblk_done}, 64'd0);
        cyc();
        mem_ack = 1'b0;
        mem_rdata = '0;
        cdb_grant = 1'b1;
        #1;
        check("lw_cdb_req", {63'd0, cdb_req}, 64'd1);
        check("lw_cdb_tag", {58'd0, cdb_out_tag}, 64'h1A);
        check("lw_cdb_data", {32'd0, cdb_out_data}, 64'hDEADBEEF);
        cyc();
        cdb_grant = 1'b0;
        #1;
        check("lw_busy_n3", {63'd0, busy}, 64'd0);
        check("lw_cdb_off", {63'd0, cdb_req}, 64'd0);

        // SB to byte 3: replicated lane, single byte enable, no broadcast.
        cyc();
        set_entry(1'b1, 2'b11, 32'h203, 32'h000000A5, 6'h11);
        #1;
        check("sb_done", {63'd0, issueblk_done}, 64'd1);
        cyc();
        issueque_ready = 1'b0;
        mem_ack = 1'b1;
        #1;
        check("sb_be", {60'd0, mem_be}, 64'h8);
        check("sb_wdata", {32'd0, mem_wdata}, 64'hA5A5A5A5);
        check("sb_we", {63'd0, mem_we}, 64'd1);
        check("sb_addr", {32'd0, mem_addr}, 64'h200);
        cyc();
        mem_ack = 1'b0;
        #1;
        check("sb_idle", {63'd0, busy}, 64'd0);
        check("sb_no_cdb", {63'd0, cdb_req}, 64'd0);

        // LBU from byte 2 of 0x11223344.
        cyc();
        set_entry(1'b1, 2'b10, 32'h102, 32'h0, 6'h07);
        #1;
        check("lbu_done", {63'd0, issueblk_done}, 64'd1);
        cyc();
        issueque_ready = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'h11223344;
        #1;
        check("lbu_be", {60'd0, mem_be}, 64'h4);
        check("lbu_we", {63'd0, mem_we}, 64'd0);
        cyc();
        mem_ack = 1'b0;
        mem_rdata = '0;
        cdb_grant = 1'b1;
        #1;
        check("lbu_data", {32'd0, cdb_out_data}, 64'h22);
        check("lbu_tag", {58'd0, cdb_out_tag}, 64'h07);
        cyc();
        cdb_grant = 1'b0;

        // Memory stalls 5 cycles, grant delayed 3, queue head held ready throughout.
        set_entry(1'b1, 2'b00, 32'h308, 32'h0, 6'h2C);
        #1;
        check("stall_done", {63'd0, issueblk_done}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("stall_mem_req", {63'd0, mem_req}, 64'd1);
            check("stall_mem_addr", {32'd0, mem_addr}, 64'h308);
            check("stall_mem_done", {63'd0, issueblk_done}, 64'd0);
        end
        cyc();
        mem_ack = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        #1;
        check("stall_ack_req", {63'd0, mem_req}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            mem_ack = 1'b0;
            mem_rdata = '0;
            #1;
            check("stall_cdb_req", {63'd0, cdb_req}, 64'd1);
            check("stall_cdb_tag", {58'd0, cdb_out_tag}, 64'h2C);
            check("stall_cdb_data", {32'd0, cdb_out_data}, 64'hCAFEF00D);
            check("stall_cdb_done", {63'd0, issueblk_done}, 64'd0);
        end
        cyc();
        cdb_grant = 1'b1;
        #1;
        check("stall_grant_done", {63'd0, issueblk_done}, 64'd0);
        cyc();
        cdb_grant = 1'b0;
        #1;
        check("stall_idle_busy", {63'd0, busy}, 64'd0);
        check("stall_next_done", {63'd0, issueblk_done}, 64'd1);

        // The re-accepted entry is aborted by reset mid-MEM; a stray ack follows.
        cyc();
        issueque_ready = 1'b0;
        #1;
        check("abort_in_mem", {63'd0, mem_req}, 64'd1);
        reset = 1'b1;
        #1;
        check("abort_rst_outs", {63'd0, any_output()}, 64'd0);
        cyc();
        reset = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        #1;
        check("abort_post_outs", {63'd0, any_output()}, 64'd0);
        cyc();
        mem_ack = 1'b0;
        mem_rdata = '0;
        #1;
        check("abort_no_cdb", {63'd0, cdb_req}, 64'd0);
        check("abort_idle", {63'd0, busy}, 64'd0);
        cyc();
        set_entry(1'b1, 2'b01, 32'h40, 32'h12345678, 6'h00);
        #1;
        check("post_rst_done", {63'd0, issueblk_done}, 64'd1);
        cyc();
        issueque_ready = 1'b0;
        mem_ack = 1'b1;
        #1;
        check("post_rst_wdata", {32'd0, mem_wdata}, 64'h12345678);
        check("post_rst_be", {60'd0, mem_be}, 64'hF);
        check("post_rst_addr", {32'd0, mem_addr}, 64'h40);
        check("post_rst_we", {63'd0, mem_we}, 64'd1);
        cyc();
        mem_ack = 1'b0;
        #1;
        check("post_rst_idle", {63'd0, busy}, 64'd0);

        // Back-to-back drain of SW, LW, SB, LBU with always-ready memory and CDB.
        q[0] = '{op: 2'b01, addr: 32'h600, rs2: 32'h55667788, tag: 6'h01};
        q[1] = '{op: 2'b00, addr: 32'h500, rs2: 32'h0,        tag: 6'h05};
        q[2] = '{op: 2'b11, addr: 32'h601, rs2: 32'h0000003C, tag: 6'h02};
        q[3] = '{op: 2'b10, addr: 32'h501, rs2: 32'h0,        tag: 6'h3F};
        idx = 0;
        n_done = 0;
        n_bcast = 0;
        for (int c = 0; c < 40 && n_bcast < 2; c++) begin
            cyc();
            mem_ack = 1'b0;
            cdb_grant = 1'b0;
            if (idx < 4) set_entry(1'b1, q[idx].op, q[idx].addr, q[idx].rs2, q[idx].tag);
            else issueque_ready = 1'b0;
            #1;
            mem_ack = mem_req;
            mem_rdata = 32'h0A0B0C0D;
            cdb_grant = cdb_req;
            #1;
            if (issueblk_done) begin
                n_done++;
                if (idx < 4) begin
                    done_op[idx] = issueque_opcode;
                    done_cyc[idx] = c;
                    idx++;
                end
            end
            if (cdb_req && n_bcast < 2) begin
                bc_tag[n_bcast] = cdb_out_tag;
                bc_data[n_bcast] = cdb_out_data;
                n_bcast++;
            end
        end
        cyc();
        mem_ack = 1'b0;
        cdb_grant = 1'b0;
        issueque_ready = 1'b0;
        #1;
        check("b2b_n_done", 64'(n_done), 64'd4);
        check("b2b_n_bcast", 64'(n_bcast), 64'd2);
        check("b2b_op0", {62'd0, done_op[0]}, 64'd1);
        check("b2b_op1", {62'd0, done_op[1]}, 64'd0);
        check("b2b_op2", {62'd0, done_op[2]}, 64'd3);
        check("b2b_op3", {62'd0, done_op[3]}, 64'd2);
        check("b2b_cyc0", 64'(done_cyc[0]), 64'd0);
        check("b2b_cyc1", 64'(done_cyc[1]), 64'd2);
        check("b2b_cyc2", 64'(done_cyc[2]), 64'd5);
        check("b2b_cyc3", 64'(done_cyc[3]), 64'd7);
        check("b2b_tag0", {58'd0, bc_tag[0]}, 64'h05);
        check("b2b_data0", {32'd0, bc_data[0]}, 64'h0A0B0C0D);
        check("b2b_tag1", {58'd0, bc_tag[1]}, 64'h3F);
        check("b2b_data1", {32'd0, bc_data[1]}, 64'h0000000C);
        check("b2b_idle", {63'd0, busy}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
